pattern_checker: RTL

Receive-side counterpart of the flat-field pattern generator: consumes the RGB pixel stream plus timing (vsync, de, hcnt, vcnt) at the far end of the video path and checks every active pixel against the grey level the selected mode requires. Accumulates per-frame pixel and error counts, captures the first mismatch location, and issues a one-cycle frame report at each frame boundary. Used on the bench and in loopback self-test to qualify the sink path.

---
 rtl/pattern_pkg.sv | 38 +++
 rtl/pattern_checker_sync_edge_det.sv | 22 ++
 rtl/pattern_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the flat-field pattern generator and checker.
// Both ends import this package, so their mode encodings and grey levels stay identical.
package pattern_pkg;

    typedef enum logic [3:0] {
        MODE_WHITE   = 4'd0,
        MODE_GREY127 = 4'd1,
        MODE_GREY159 = 4'd2,
        MODE_GREY95  = 4'd3
    } pattern_mode_t;

    localparam logic [7:0] LEVEL_WHITE   = 8'd255;
    localparam logic [7:0] LEVEL_GREY127 = 8'd127;
    localparam logic [7:0] LEVEL_GREY159 = 8'd159;
    localparam logic [7:0] LEVEL_GREY95  = 8'd95;
    localparam int         MODE_COUNT    = 4;

    typedef enum logic {
        ST_IDLE,
        ST_CHECK
    } check_state_t;

    function automatic logic mode_valid(input logic [3:0] mode);
        return mode < 4'(MODE_COUNT);
    endfunction

    // Invalid modes map to 0; callers gate on mode_valid before trusting the level.
    function automatic logic [7:0] mode_level(input logic [3:0] mode);
        case (mode)
            MODE_WHITE:   mode_level = LEVEL_WHITE;
            MODE_GREY127: mode_level = LEVEL_GREY127;
            MODE_GREY159: mode_level = LEVEL_GREY159;
            MODE_GREY95:  mode_level = LEVEL_GREY95;
            default:      mode_level = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/pattern_checker_sync_edge_det.sv
// Registered rising-edge detector: rise is high in the cycle where din is 1
// and the registered previous sample is 0.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/pattern_checker.sv
// Receive-side flat-field checker: counts active and mismatching pixels per frame
// and reports them, with the first error location, on every vsync rising edge.
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int ERR_W = 16,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode,
    input  logic             vsync,
    input  logic             de,
    input  logic [10:0]      hcnt,
    input  logic [11:0]      vcnt,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    output logic             frame_done,
    output logic             frame_pass,
    output logic [ERR_W-1:0] err_count,
    output logic [PIX_W-1:0] pix_count,
    output logic [10:0]      first_err_h,
    output logic [11:0]      first_err_v,
    output logic [15:0]      frame_count
);

    check_state_t     state;
    logic             vs_rise;
    logic [3:0]       mode_q;
    logic [ERR_W-1:0] err_acc;
    logic [PIX_W-1:0] pix_acc;
    logic [10:0]      fe_h;
    logic [11:0]      fe_v;
    logic [3:0]       cur_mode;
    logic [7:0]       level;
    logic             in_frame;
    logic             mismatch;

    sync_edge_det u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (vsync),
        .rise (vs_rise)
    );

    // A pixel arriving in the edge cycle already belongs to the new frame,
    // so it is judged against the mode being latched in that same cycle.
    assign cur_mode = vs_rise ? mode : mode_q;
    assign level    = mode_level(cur_mode);
    assign in_frame = vs_rise || (state == ST_CHECK);
    assign mismatch = in_frame && de && mode_valid(cur_mode) &&
                      ((R != level) || (G != level) || (B != level));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= '0;
            err_acc     <= '0;
            pix_acc     <= '0;
            fe_h        <= '0;
            fe_v        <= '0;
            frame_done  <= 1'b0;
            frame_pass  <= 1'b0;
            err_count   <= '0;
            pix_count   <= '0;
            first_err_h <= '0;
            first_err_v <= '0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (vs_rise) begin
                // The first edge after reset only opens a frame; there is nothing to report yet.
                if (state == ST_CHECK) begin
                    frame_done  <= 1'b1;
                    frame_pass  <= mode_valid(mode_q) && (err_acc == '0) && (pix_acc != '0);
                    err_count   <= err_acc;
                    pix_count   <= pix_acc;
                    first_err_h <= fe_h;
                    first_err_v <= fe_v;
                    frame_count <= frame_count + 16'd1;
                end
                state   <= ST_CHECK;
                mode_q  <= mode;
                pix_acc <= PIX_W'(de);
                err_acc <= ERR_W'(mismatch);
                fe_h    <= mismatch ? hcnt : '0;
                fe_v    <= mismatch ? vcnt : '0;
            end else if (state == ST_CHECK && de) begin
                if (pix_acc != '1) begin
                    pix_acc <= pix_acc + PIX_W'(1);
                end
                if (mismatch) begin
                    if (err_acc == '0) begin
                        fe_h <= hcnt;
                        fe_v <= vcnt;
                    end
                    if (err_acc != '1) begin
                        err_acc <= err_acc + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule
